// File: rtl/audio_prefetch.sv
// Purpose: prefetches PCM samples from sample memory into a FWFT FIFO feeding the serializer.
// Latency: memory data lands in the FIFO 2 cycles after the read is issued (renb -> data -> push).
// Backpressure: reads stall while FIFO count plus in-flight reads reaches DEPTH; i_ready pops the head.
// Build option: define AUDIO_PREFETCH_LOOP_EN to loop playback from LAST_ADDR back to address 0.
module audio_prefetch #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter logic [ADDR_W-1:0] LAST_ADDR = 16'hFFFF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_renb,
  input  logic [DATA_W-1:0] i_mem_data,
  output logic [DATA_W-1:0] o_sample,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_underrun
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic              in_flight;
  logic [DATA_W-1:0] fifo_mem [DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     occupancy;

  logic start_acc, abort, flush, push, pop, last_rd;

  // A start is only honoured from IDLE and loses to a simultaneous stop.
  assign start_acc = (state == S_IDLE) && i_start && !i_stop;
  assign abort     = o_busy && i_stop;
  assign flush     = start_acc || abort;
  // Read data returning after an abort is dropped rather than pushed.
  assign push      = in_flight && !abort;
  assign pop       = o_valid && i_ready;

  // Slots already promised to outstanding reads count against FIFO space.
  assign occupancy  = count + CW'(in_flight);
  assign o_mem_renb = (state == S_RUN) && (occupancy < CW'(DEPTH));
  assign last_rd    = o_mem_renb && (addr == LAST_ADDR);

  assign o_mem_addr = addr;
  assign o_valid    = (count != '0);
  assign o_sample   = fifo_mem[rd_ptr];
  assign o_busy     = (state == S_RUN) || (state == S_DRAIN);
  assign o_done     = (state == S_DONE);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic; stop always overrides end-of-data handling.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:  if (start_acc) state_nxt = S_RUN;
      S_RUN: begin
        if (i_stop) state_nxt = S_IDLE;
`ifdef AUDIO_PREFETCH_LOOP_EN
        else        state_nxt = S_RUN;
`else
        else if (last_rd) state_nxt = S_DRAIN;
`endif
      end
      S_DRAIN: begin
        if (i_stop) state_nxt = S_IDLE;
        else if ((count == '0) && !in_flight) state_nxt = S_DONE;
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Read address: post-increment per read; at LAST_ADDR either wrap (loop) or hold.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      addr <= '0;
    end else if (start_acc) begin
      addr <= '0;
    end else if (o_mem_renb) begin
`ifdef AUDIO_PREFETCH_LOOP_EN
      addr <= last_rd ? '0 : addr + ADDR_W'(1);
`else
      addr <= last_rd ? addr : addr + ADDR_W'(1);
`endif
    end
  end

  // Tracks the single-cycle memory latency; cleared on abort to discard the return.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)   in_flight <= 1'b0;
    else if (abort) in_flight <= 1'b0;
    else            in_flight <= o_mem_renb;
  end

  // FIFO pointers and count; flush wins over push/pop.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; cleared on reset so the head reads 0 until the first push.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) fifo_mem[i] <= '0;
    end else if (push) begin
      fifo_mem[wr_ptr] <= i_mem_data;
    end
  end

  // Sticky starvation flag: serializer asked for data the FIFO did not have.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                      o_underrun <= 1'b0;
    else if (start_acc)                                o_underrun <= 1'b0;
    else if ((state == S_RUN) && i_ready && !o_valid)  o_underrun <= 1'b1;
  end

endmodule

// File: tb/tb_audio_prefetch.sv
module tb_audio_prefetch;

  localparam int DEPTH = 8;
`ifdef AUDIO_PREFETCH_LOOP_EN
  localparam int NS = 20;
`else
  localparam int NS = 16;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        ready = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] mem_addr;
  logic        mem_renb;
  logic [15:0] sample;
  logic        valid, busy, done, underrun;

  int          n_tests = 0;
  int          n_fail = 0;
  int          nreads = 0;
  logic [15:0] last_rd = 16'h0;

  audio_prefetch #(
    .ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .LAST_ADDR(16'd15)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stop(stop),
    .o_mem_addr(mem_addr), .o_mem_renb(mem_renb), .i_mem_data(mem_rdata),
    .o_sample(sample), .o_valid(valid), .i_ready(ready),
    .o_busy(busy), .o_done(done), .o_underrun(underrun)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] mem_val(input int a);
    return 16'hC000 | 16'(a);
  endfunction

  // Sample memory: one-cycle read latency, garbage when not reading.
  always @(posedge clk) begin
    if (mem_renb) begin
      mem_rdata <= mem_val(int'(mem_addr));
      nreads    <= nreads + 1;
      last_rd   <= mem_addr;
    end else begin
      mem_rdata <= 16'hDEAD;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nclk(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int base, idx, cyc, done_cnt;

    // Reset state
    nclk(2);
    chk("rst_renb", mem_renb, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_sample", sample, 0);
    rst_n = 1'b1;
    nclk(2);

    // Fill with no consumer: exactly DEPTH reads
    base = nreads;
    start = 1'b1; nclk(1); start = 1'b0;
    nclk(20);
    chk("fill_reads", nreads - base, DEPTH);
    chk("fill_last_addr", last_rd, 7);
    chk("fill_addr", mem_addr, 8);
    chk("fill_valid", valid, 1);
    chk("fill_sample", sample, mem_val(0));
    chk("fill_renb", mem_renb, 0);
    chk("fill_busy", busy, 1);

    // Stream everything out in order
    ready = 1'b1; idx = 0; cyc = 0; done_cnt = 0;
    while (idx < NS && cyc < 200) begin
      if (done) done_cnt++;
      if (valid) begin
        chk($sformatf("stream_%0d", idx), sample, mem_val(idx % 16));
        idx++;
      end
      nclk(1);
      cyc++;
    end
    chk("stream_count", idx, NS);
    chk("stream_no_underrun", underrun, 0);
    repeat (10) begin
      if (done) done_cnt++;
      nclk(1);
    end
`ifdef AUDIO_PREFETCH_LOOP_EN
    chk("loop_no_done", done_cnt, 0);
    chk("loop_busy", busy, 1);
    stop = 1'b1; nclk(1); stop = 1'b0;
    chk("loop_stop_busy", busy, 0);
`else
    chk("done_pulses", done_cnt, 1);
    chk("end_idle_busy", busy, 0);
    chk("end_addr_hold", mem_addr, 15);
`endif
    ready = 1'b0;
    nclk(2);

    // Underrun: consumer ready from the cycle after start
    start = 1'b1; nclk(1); start = 1'b0; ready = 1'b1;
    chk("ur_initial", underrun, 0);
    nclk(1);
    chk("ur_set", underrun, 1);
    chk("ur_set_valid", valid, 0);
    nclk(1);
    chk("ur_first_valid", valid, 1);
    chk("ur_first_sample", sample, mem_val(0));
    nclk(3);
    chk("ur_sticky", underrun, 1);
    stop = 1'b1; nclk(1); stop = 1'b0; ready = 1'b0;
    nclk(1);
    chk("ur_after_stop", underrun, 1);
    chk("ur_after_stop_busy", busy, 0);

    // Stop with 5 buffered + 1 in flight; simultaneous start must lose
    base = nreads;
    start = 1'b1; nclk(1); start = 1'b0;
    chk("ur_cleared", underrun, 0);
    nclk(6);
    chk("pre_stop_reads", nreads - base, 6);
    chk("pre_stop_valid", valid, 1);
    stop = 1'b1; start = 1'b1; nclk(1); stop = 1'b0; start = 1'b0;
    chk("stop_valid", valid, 0);
    chk("stop_busy", busy, 0);
    chk("stop_done", done, 0);
    nclk(1);
    chk("stop_no_push", valid, 0);
    chk("stop_start_ignored", busy, 0);
    nclk(3);
    chk("stop_still_empty", valid, 0);
    chk("stop_never_done", done, 0);

    // Reset pulse mid-RUN
    start = 1'b1; nclk(1); start = 1'b0;
    nclk(4);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_renb", mem_renb, 0);
    chk("mid_rst_valid", valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_addr", mem_addr, 0);
    chk("mid_rst_sample", sample, 0);
    nclk(1);
    rst_n = 1'b1;
    nclk(3);
    chk("post_rst_no_push", valid, 0);
    chk("post_rst_renb", mem_renb, 0);
    chk("post_rst_done", done, 0);
    start = 1'b1; nclk(1); start = 1'b0;
    chk("restart_addr", mem_addr, 0);
    chk("restart_renb", mem_renb, 1);
    nclk(2);
    chk("restart_valid", valid, 1);
    chk("restart_sample", sample, mem_val(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_prefetch.md
AUDIO_PREFETCH -- requirements
Module: audio_prefetch

Interface
REQ-001 Parameter ADDR_W, default 16, sample memory address width.
REQ-002 Parameter DATA_W, default 16, PCM sample width.
REQ-003 Parameter DEPTH, default 8, FIFO entries; power of two, at least 2.
REQ-004 Parameter LAST_ADDR, default 16'hFFFF, final sample address.
REQ-005 Port i_clk, input, 1 bit: the only clock, 12 MHz codec domain; all logic on the rising edge.
REQ-006 Port i_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 Port i_start, input, 1 bit: one-cycle pulse that starts playback.
REQ-008 Port i_stop, input, 1 bit: one-cycle pulse that aborts playback.
REQ-009 Port o_mem_addr, output, ADDR_W bits: sample memory read address.
REQ-010 Port o_mem_renb, output, 1 bit: sample memory read enable.
REQ-011 Port i_mem_data, input, DATA_W bits: memory read data, valid exactly 1 cycle after o_mem_renb.
REQ-012 Port o_sample, output, DATA_W bits: FIFO head sample to the serializer.
REQ-013 Port o_valid, output, 1 bit: o_sample holds valid data.
REQ-014 Port i_ready, input, 1 bit: serializer consumes the head sample.
REQ-015 Port o_busy, output, 1 bit: high in RUN or DRAIN.
REQ-016 Port o_done, output, 1 bit: one-cycle pulse at the end of playback.
REQ-017 Port o_underrun, output, 1 bit: sticky starvation flag.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN and DONE; the encoding is free.
REQ-019 IDLE SHALL hold o_mem_renb=0; on i_start it SHALL flush the FIFO, set the address to 0, clear o_underrun and go to RUN.
REQ-020 RUN SHALL assert o_mem_renb when FIFO count plus in-flight reads is below DEPTH; the FIFO SHALL never overflow.
REQ-021 Each issued read SHALL post-increment the address; the returned data SHALL be pushed into the FIFO on the following cycle.
REQ-022 A read of LAST_ADDR SHALL take the end-of-data action defined in Configuration.
REQ-023 DRAIN SHALL issue no reads; once the FIFO is empty and no read is in flight, the FSM SHALL go to DONE.
REQ-024 DONE SHALL assert o_done for exactly 1 cycle, then go to IDLE.
REQ-025 i_stop in RUN or DRAIN SHALL return the FSM to IDLE on the next edge, flush the FIFO and discard any in-flight read data; o_done SHALL stay 0.
REQ-026 If i_stop and i_start arrive in the same cycle, i_stop SHALL win; i_start in RUN or DRAIN SHALL be ignored.
REQ-027 The FIFO SHALL be first-word-fall-through: o_valid = not empty, and o_sample shows the head combinationally from FIFO storage.
REQ-028 A pop SHALL occur when o_valid and i_ready are both high; a push and pop in the same cycle SHALL leave the count unchanged.
REQ-029 i_ready with o_valid=0 while in RUN SHALL set o_underrun; the flag SHALL hold until the next accepted i_start.
REQ-030 FIFO pointers SHALL wrap modulo DEPTH, and the count SHALL range 0..DEPTH.

Reset
REQ-031 i_rst_n=0 SHALL immediately force IDLE, address 0, FIFO empty, no read in flight, and o_mem_renb=0, o_valid=0, o_busy=0, o_done=0, o_underrun=0, o_mem_addr=0.
REQ-032 o_sample SHALL read 0 during and after reset until the first push.
REQ-033 Reset asserted mid-playback SHALL discard the in-flight read, and no push SHALL occur after reset is released.

Configuration
REQ-034 With AUDIO_PREFETCH_LOOP_EN defined, a read of LAST_ADDR SHALL wrap the address to 0 and stay in RUN; playback ends only on i_stop.
REQ-035 Without AUDIO_PREFETCH_LOOP_EN, a read of LAST_ADDR SHALL move the FSM to DRAIN; the address SHALL hold LAST_ADDR.

Verification
REQ-036 Reset, then i_start with i_ready=0 and DEPTH=8 -> exactly 8 reads at addresses 0..7, o_valid=1, o_sample=mem[0], o_mem_renb stays 0.
REQ-037 LAST_ADDR=15, i_ready=1 continuously, loop macro off -> 16 samples in order mem[0..15], then a single o_done pulse, then IDLE.
REQ-038 Same as REQ-037 with AUDIO_PREFETCH_LOOP_EN -> after mem[15] the next sample is mem[0], o_done never asserts.
REQ-039 i_stop with 1 read in flight and 5 samples buffered -> next cycle o_valid=0, o_busy=0, no push, o_done=0.
REQ-040 i_ready held high from the cycle after i_start -> o_underrun=1 in the first-data cycle and stays 1; the next i_start clears it.
REQ-041 i_rst_n pulsed low for 1 cycle mid-RUN -> all outputs 0 immediately, no push, and i_start afterwards restarts at address 0.
